// File: rtl/csd_pkg.sv
// Shared types and constants for the CSD shift-add coefficient multiplier.
// The term record uses the default 4-bit shift field; wider SHW values are formed in the top level.
package csd_pkg;

  localparam int DEF_SHW    = 4;
  localparam int DEF_NTERMS = 5;

  typedef struct packed {
    logic               en;
    logic               neg;
    logic [DEF_SHW-1:0] shift;
  } term_t;

  // Reset coefficient: 2^-1 + 2^-4 + 2^-7 + 2^-10 + 2^-13, roughly 4/7.
  localparam term_t DEFAULT_TERMS [DEF_NTERMS] = '{
    '{en: 1'b1, neg: 1'b0, shift: 4'd1},
    '{en: 1'b1, neg: 1'b0, shift: 4'd4},
    '{en: 1'b1, neg: 1'b0, shift: 4'd7},
    '{en: 1'b1, neg: 1'b0, shift: 4'd10},
    '{en: 1'b1, neg: 1'b0, shift: 4'd13}
  };

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic term_t default_term(input int idx);
    term_t t;
    t = '0;
    if (idx < DEF_NTERMS) t = DEFAULT_TERMS[idx];
    return t;
  endfunction

endpackage

// File: rtl/csd_term.sv
// One shift-add term: sign-extend, arithmetic right shift (floor), optional negate.
// Purely combinational; the caller registers the result.
module csd_term
  import csd_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int GUARD = 4,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0]       data,
  input  logic                   en,
  input  logic                   neg,
  input  logic [SHW-1:0]         shift,
  output logic [WIDTH+GUARD-1:0] term
);

  localparam int SW = WIDTH + GUARD;

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] shifted;

  always_comb begin
    ext     = {{GUARD{data[WIDTH-1]}}, data};
    shifted = ext >>> shift;
    term    = '0;
    if (en) term = neg ? -shifted : shifted;
  end

endmodule

// File: rtl/csd_coef_mult.sv
// Pipelined constant-coefficient multiplier built from a runtime-programmable,
// double-buffered bank of CSD shift-add terms, with saturating output.
module csd_coef_mult
  import csd_pkg::*;
#(
  parameter int WIDTH  = 41,
  parameter int NTERMS = 5,
  parameter int SHW    = 4,
  parameter int GUARD  = 4,
  localparam int IDXW  = clog2(NTERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [SHW+1:0]   cfg_term,
  input  logic             cfg_commit,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat
);

  localparam int SW = WIDTH + GUARD;

  localparam logic signed [SW-1:0] MAX_EXT = {{(GUARD + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_EXT = {{(GUARD + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic [SW-1:0] term_q [NTERMS];

  logic                 v1_reg;
  logic                 v2_reg;
  logic signed [SW-1:0] sum_next;
  logic signed [SW-1:0] sum_reg;
  logic [WIDTH-1:0]     out_data_next;
  logic                 out_sat_next;

  generate
    for (genvar gi = 0; gi < NTERMS; gi++) begin : g_term
      localparam term_t          DEF_T    = default_term(gi);
      localparam logic [SHW+1:0] DEF_BITS = {DEF_T.en, DEF_T.neg, SHW'(DEF_T.shift)};

      logic [SHW+1:0] shadow_reg;
      logic [SHW+1:0] active_reg;
      logic [SW-1:0]  term_next;
      logic [SW-1:0]  term_reg;

      // Non-blocking semantics make a same-cycle commit copy the pre-write shadow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= DEF_BITS;
          active_reg <= DEF_BITS;
        end else begin
          if (cfg_commit) active_reg <= shadow_reg;
          if (cfg_we && (cfg_idx == IDXW'(gi))) shadow_reg <= cfg_term;
        end
      end

      csd_term #(
        .WIDTH (WIDTH),
        .GUARD (GUARD),
        .SHW   (SHW)
      ) u_term (
        .data  (in_data),
        .en    (active_reg[SHW+1]),
        .neg   (active_reg[SHW]),
        .shift (active_reg[SHW-1:0]),
        .term  (term_next)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          term_reg <= '0;
        end else if (in_valid) begin
          term_reg <= term_next;
        end
      end

      assign term_q[gi] = term_reg;
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NTERMS; i++) begin
      sum_next = sum_next + $signed(term_q[i]);
    end
  end

  always_comb begin
    out_sat_next  = 1'b0;
    out_data_next = sum_reg[WIDTH-1:0];
    if (sum_reg > MAX_EXT) begin
      out_sat_next  = 1'b1;
      out_data_next = MAX_EXT[WIDTH-1:0];
    end else if (sum_reg < MIN_EXT) begin
      out_sat_next  = 1'b1;
      out_data_next = MIN_EXT[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      out_valid <= 1'b0;
      sum_reg   <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      v1_reg    <= in_valid;
      v2_reg    <= v1_reg;
      out_valid <= v2_reg;
      if (v1_reg) sum_reg <= sum_next;
      if (v2_reg) begin
        out_data <= out_data_next;
        out_sat  <= out_sat_next;
      end
    end
  end

endmodule

// File: doc/csd_coef_mult.md
Name: csd_coef_mult

Overview:
Parametrised, pipelined constant-coefficient multiplier for the delta-sigma modulator loop-filter coefficients. The product is formed as a signed sum of arithmetically right-shifted copies of the input (CSD shift-add), so no hard multiplier is used. The coefficient is held in a runtime-programmable, double-buffered term bank. The output saturates to the datapath width and carries a valid strobe. It replaces the fixed per-coefficient shift-add blocks in the loop filter.

Parameters:
WIDTH, 41, datapath width of in_data/out_data (signed two's complement).
NTERMS, 5, number of shift-add terms in the bank.
SHW, 4, width of each term's shift field; maximum shift is 2^SHW-1.
GUARD, 4, internal guard bits; must satisfy GUARD >= clog2(NTERMS)+1.

Ports:
clk  in  1  clock; all logic is rising-edge triggered.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_data is valid this cycle.
in_data  in  WIDTH  signed input sample.
cfg_we  in  1  write a single term into the shadow bank.
cfg_idx  in  clog2(NTERMS)  index of the term being written.
cfg_term  in  SHW+2  term encoding: {en, neg, shift[SHW-1:0]}.
cfg_commit  in  1  copy the shadow bank into the active bank.
out_valid  out  1  out_data and out_sat are valid this cycle.
out_data  out  WIDTH  signed, saturated product.
out_sat  out  1  saturation occurred on this sample.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_sat=0.
  - Valid pipeline cleared.
  - Shadow and active banks both load the default coefficient: terms 0..4 = {en=1, neg=0, shift=1,4,7,10,13}, which approximates 4/7.
  - Terms with index >= 5 reset to en=0.
- Term value:
  - en=0 contributes 0.
  - Otherwise the term is in_data arithmetically right-shifted by shift, with floor truncation and sign extension.
  - The result is widened to WIDTH+GUARD and negated (two's complement) if neg=1.
  - Shift 0 is legal and passes in_data unchanged.
- Pipeline (fixed latency 3; no backpressure; one sample per cycle):
  - S1 registers the NTERMS shifted/negated terms using the active bank.
  - S2 registers the full-precision sum in WIDTH+GUARD bits.
  - S3 saturates to WIDTH and registers out_data/out_sat.
- out_valid is in_valid delayed by exactly 3 cycles.
- Data registers at each stage load only when their stage-valid is 1. When out_valid=0, out_data and out_sat hold their last values.
- Saturation:
  - sum > 2^(WIDTH-1)-1 gives out_data = max, out_sat=1.
  - sum < -2^(WIDTH-1) gives out_data = min, out_sat=1.
  - Otherwise out_sat=0.
- Configuration:
  - cfg_we writes cfg_term into shadow[cfg_idx]. cfg_idx >= NTERMS is ignored.
  - cfg_commit copies the entire shadow bank into the active bank at the clock edge.
  - A sample with in_valid=1 in the commit cycle uses the OLD active bank. The first sample using the new bank is the one presented in the cycle after commit.
  - Samples already in flight in S2/S3 are never affected.
  - When cfg_we and cfg_commit are asserted in the same cycle, the commit copies the pre-write shadow; the write lands in the shadow only.
- Reset asserted mid-operation clears everything immediately (asynchronous), including any programmed coefficient, and restores the defaults. Samples in flight are discarded with no out_valid.
- The active bank is stable between commits. The shadow bank may be rewritten freely without affecting output.

Decomposition:
- Package csd_pkg holds:
  - term record type {en, neg, shift}.
  - DEFAULT_TERMS constant array (shifts 1,4,7,10,13, all positive, enabled).
  - helper function for clog2.
- One sub-module, csd_term: combinational shift/sign-extend/negate for a single term, instantiated NTERMS times inside S1.
- Bank registers, adder, saturation and valid pipeline live in the top level.

Test Plan:
- Default bank, in_data=1048576 (2^20) with in_valid pulsed for one cycle -> out_valid exactly 3 cycles later; out_data=599168, out_sat=0.
- Default bank, in_data=-8192 -> out_data=-4681 (floor truncation per term: -4096-512-64-8-1); out_sat=0.
- Write terms 0..4 = {1,0,0} and commit; in_data=2^39 -> out_data=2^40-1, out_sat=1. in_data=-2^40 -> out_data=-2^40, out_sat=1.
- Back-to-back stream of in_data=1024 with a commit midway, switching from the default bank to a single term {1,1,0}:
  - samples up to and including the commit cycle give 585;
  - samples from the next cycle onward give -1024;
  - no bubble appears.
- cfg_we and cfg_commit asserted in the same cycle -> the active bank reflects the pre-write shadow; a second commit then applies the write. cfg_idx=NTERMS is ignored.
- Program a custom bank, then drop rst_n for 1 cycle with samples in flight -> outputs go to 0 immediately, no out_valid appears for the in-flight samples, and the next input uses the default coefficient (2^20 -> 599168).
